vasya_s27_bist_ctrl: RTL and testbench

//  Pattern source and response sink for the s27 benchmark core: drives G0..G3 from a 4-bit

---
 rtl/vasya_s27_bist_pkg.sv | 25 ++
 rtl/vasya_s27_misr.sv | 26 ++
 rtl/vasya_s27_bist_ctrl.sv | 115 +++++++++++
 tb/tb_vasya_s27_bist_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vasya_s27_bist_pkg.sv
// Shared types and constants for the s27 BIST controller: FSM state encoding,
// LFSR/MISR widths, MISR feedback polynomial, LFSR taps and the LFSR step function.
package vasya_s27_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int              LFSR_W     = 4;
    localparam int              MISR_W     = 8;
    localparam int              CNT_W      = 8;
    localparam logic [MISR_W-1:0] MISR_POLY = 8'h1D;

    // Taps of the maximal-length x^4 + x^3 + 1 shift register.
    localparam int LFSR_TAP_HI = 3;
    localparam int LFSR_TAP_LO = 2;

    // One LFSR advance: shift left, feed back the XOR of the two taps.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[LFSR_TAP_HI] ^ l[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/vasya_s27_misr.sv
// 8-bit multiple-input signature register compacting the single-bit s27 response.
// clr zeroes the signature; en absorbs din on the rising edge.
module vasya_s27_misr
    import vasya_s27_bist_pkg::*;
(
    input  logic              CK,
    input  logic              RST,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [MISR_W-1:0] sig
);

    // Signature register: shift with polynomial feedback, XOR in the new response bit.
    always_ff @(posedge CK) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (RST || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[MISR_W-2:0], 1'b0}
                 ^ (sig[MISR_W-1] ? MISR_POLY : '0)
                 ^ {{(MISR_W-1){1'b0}}, din};
        end
    end

endmodule

// File: rtl/vasya_s27_bist_ctrl.sv
// BIST controller for the s27 core: applies PATTERNS vectors from a 4-bit LFSR on
// G0..G3 and compacts G17 into an 8-bit MISR signature reported on SIG with DONE.
// Optional build macro VASYA_S27_BIST_GOLDEN_CMP_EN adds a PASS output comparing
// the final signature against GOLDEN.
module vasya_s27_bist_ctrl
    import vasya_s27_bist_pkg::*;
#(
    parameter int                PATTERNS = 15,
    parameter logic [LFSR_W-1:0] SEED     = 4'b0001,
    parameter logic [MISR_W-1:0] GOLDEN   = 8'h00
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              START,
    input  logic              G17,
    output logic              G0,
    output logic              G1,
    output logic              G2,
    output logic              G3,
    output logic              BUSY,
    output logic              DONE,
    output logic [MISR_W-1:0] SIG
`ifdef VASYA_S27_BIST_GOLDEN_CMP_EN
    ,
    output logic              PASS
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS - 1);

    // An all-zero seed locks the LFSR; the counter limits the run length.
    if (SEED == '0) begin : g_bad_seed
        $error("vasya_s27_bist_ctrl: SEED must be non-zero");
    end
    if (PATTERNS < 1 || PATTERNS > 255) begin : g_bad_patterns
        $error("vasya_s27_bist_ctrl: PATTERNS must be within 1..255");
    end

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                load;
    logic                advance;
    logic                run;

    // State register; reset wins over any pending START.
    always_ff @(posedge CK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode plus the load/advance strobes for LFSR, counter and MISR.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                advance = 1'b1;
                if (cnt_q == LAST_CNT) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pattern generator and vector counter: reload on entry to RUN, step on each RUN edge.
    always_ff @(posedge CK) begin
        if (RST || load) begin
            lfsr_q <= SEED;
            cnt_q  <= '0;
        end else if (advance) begin
            lfsr_q <= lfsr_next(lfsr_q);
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    vasya_s27_misr u_misr (
        .CK  (CK),
        .RST (RST),
        .clr (load),
        .en  (advance),
        .din (G17),
        .sig (SIG)
    );

    // Outputs are pure decodes of registered state, never of G17.
    always_comb begin
        run  = (state_q == ST_RUN);
        BUSY = run;
        DONE = (state_q == ST_DONE);
        G0   = run & lfsr_q[0];
        G1   = run & lfsr_q[1];
        G2   = run & lfsr_q[2];
        G3   = run & lfsr_q[3];
    end

`ifdef VASYA_S27_BIST_GOLDEN_CMP_EN
    // PASS rises and falls together with DONE, since both decode the same state flops.
    always_comb begin
        PASS = (state_q == ST_DONE) && (SIG == GOLDEN);
    end
`else
    // GOLDEN has no consumer in this build; fold it into a deliberately unused net.
    logic unused_golden;
    assign unused_golden = ^GOLDEN;
`endif

endmodule

// File: tb/tb_vasya_s27_bist_ctrl.sv
// Self-checking bench for vasya_s27_bist_ctrl: four instances with different
// PATTERNS/SEED/GOLDEN share CK/RST/START/G17 and are compared every cycle with a
// behavioural model built from the published pattern table and MISR rule.
module tb_vasya_s27_bist_ctrl;

    localparam int N = 4;

    // Per-instance configuration, mirrored in the instance parameters below.
    int          pats   [N] = '{15, 3, 9, 9};
    int          offs   [N] = '{0, 0, 0, 8};      // position of SEED in the pattern table
    logic [7:0]  goldens[N] = '{8'h00, 8'h07, 8'hE2, 8'hE3};

    // Pattern sequence starting at 0001.
    logic [3:0]  seq[15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    logic CK = 1'b0;
    logic RST = 1'b1;
    logic START = 1'b0;
    logic G17 = 1'b0;

    wire [3:0] gv   [N];
    wire       busy [N];
    wire       done [N];
    wire [7:0] sig  [N];
    wire       pass [N];

    int checks = 0;
    int errors = 0;
    int g17_mode = 0;   // 0 random, 1 tied low, 2 tied high

    // Model state: 0 idle, 1 run, 2 done; k = vector index; resp = responses absorbed.
    int m_phase[N];
    int m_k    [N];
    bit m_resp [N][$];

    always #5 CK = ~CK;

`ifdef VASYA_S27_BIST_GOLDEN_CMP_EN
    `define TB_PASS(i) , .PASS(pass[i])
`else
    `define TB_PASS(i)
    assign pass[0] = 1'b0;
    assign pass[1] = 1'b0;
    assign pass[2] = 1'b0;
    assign pass[3] = 1'b0;
`endif

    vasya_s27_bist_ctrl #(.PATTERNS(15), .SEED(4'b0001), .GOLDEN(8'h00)) dut0 (
        .CK(CK), .RST(RST), .START(START), .G17(G17),
        .G0(gv[0][0]), .G1(gv[0][1]), .G2(gv[0][2]), .G3(gv[0][3]),
        .BUSY(busy[0]), .DONE(done[0]), .SIG(sig[0]) `TB_PASS(0));
    vasya_s27_bist_ctrl #(.PATTERNS(3), .SEED(4'b0001), .GOLDEN(8'h07)) dut1 (
        .CK(CK), .RST(RST), .START(START), .G17(G17),
        .G0(gv[1][0]), .G1(gv[1][1]), .G2(gv[1][2]), .G3(gv[1][3]),
        .BUSY(busy[1]), .DONE(done[1]), .SIG(sig[1]) `TB_PASS(1));
    vasya_s27_bist_ctrl #(.PATTERNS(9), .SEED(4'b0001), .GOLDEN(8'hE2)) dut2 (
        .CK(CK), .RST(RST), .START(START), .G17(G17),
        .G0(gv[2][0]), .G1(gv[2][1]), .G2(gv[2][2]), .G3(gv[2][3]),
        .BUSY(busy[2]), .DONE(done[2]), .SIG(sig[2]) `TB_PASS(2));
    vasya_s27_bist_ctrl #(.PATTERNS(9), .SEED(4'b0101), .GOLDEN(8'hE3)) dut3 (
        .CK(CK), .RST(RST), .START(START), .G17(G17),
        .G0(gv[3][0]), .G1(gv[3][1]), .G2(gv[3][2]), .G3(gv[3][3]),
        .BUSY(busy[3]), .DONE(done[3]), .SIG(sig[3]) `TB_PASS(3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Signature of a response stream, from the MISR rule applied bit by bit.
    function automatic logic [7:0] sig_of(input bit q[$]);
        logic [7:0] m = 8'h00;
        foreach (q[j]) m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {7'b0, q[j]};
        return m;
    endfunction

    // Advance every model by one clock edge using the inputs about to be sampled.
    task automatic model_update();
        for (int i = 0; i < N; i++) begin
            if (RST) begin
                m_phase[i] = 0;
                m_k[i]     = 0;
                m_resp[i].delete();
            end else if (m_phase[i] == 1) begin
                m_resp[i].push_back(G17);
                if (m_k[i] == pats[i] - 1) m_phase[i] = 2;
                else                       m_k[i]++;
            end else if (START) begin
                m_phase[i] = 1;
                m_k[i]     = 0;
                m_resp[i].delete();
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            logic [3:0] exp_g;
            logic [7:0] exp_sig;
            exp_g   = (m_phase[i] == 1) ? seq[(offs[i] + m_k[i]) % 15] : 4'h0;
            exp_sig = sig_of(m_resp[i]);
            check($sformatf("pattern%0d", i), {28'b0, gv[i]}, {28'b0, exp_g});
            check($sformatf("busy%0d", i), {31'b0, busy[i]}, {31'b0, m_phase[i] == 1});
            check($sformatf("done%0d", i), {31'b0, done[i]}, {31'b0, m_phase[i] == 2});
            if (m_phase[i] != 1)
                check($sformatf("sig%0d", i), {24'b0, sig[i]}, {24'b0, exp_sig});
`ifdef VASYA_S27_BIST_GOLDEN_CMP_EN
            check($sformatf("pass%0d", i), {31'b0, pass[i]},
                  {31'b0, (m_phase[i] == 2) && (exp_sig == goldens[i])});
`endif
        end
    endtask

    // One clock: choose G17, update the model, clock the DUTs, then compare.
    task automatic step();
        case (g17_mode)
            0:       G17 = 1'($urandom_range(0, 1));
            1:       G17 = 1'b0;
            default: G17 = 1'b1;
        endcase
        model_update();
        @(posedge CK);
        #1;
        compare_all();
    endtask

    task automatic start_pulse();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    initial begin
        // Reset, then idle with no request.
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
        step();

        // Random responses, including restarts straight from DONE.
        g17_mode = 0;
        for (int r = 0; r < 3; r++) begin
            start_pulse();
            repeat (16) step();
        end

        // Tied-low response gives an all-zero signature.
        g17_mode = 1;
        start_pulse();
        repeat (16) step();

        // Tied-high response: known signatures for 3 and 9 vectors.
        g17_mode = 2;
        start_pulse();
        repeat (16) step();
        check("ones_p3_sig", {24'b0, sig[1]}, 32'h07);
        check("ones_p9_sig", {24'b0, sig[2]}, 32'hE2);

        // Reset on the 5th RUN cycle, then rerun with the same response.
        start_pulse();
        repeat (4) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
        start_pulse();
        repeat (16) step();
        check("rerun_p9_sig", {24'b0, sig[2]}, 32'hE2);

        // START held through RUN: long run is not restarted, short ones loop via DONE.
        g17_mode = 0;
        START = 1'b1;
        repeat (17) step();
        START = 1'b0;
        repeat (16) step();

        // Reset takes priority over START.
        RST   = 1'b1;
        START = 1'b1;
        step();
        RST   = 1'b0;
        START = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
